ble_tx_frame_scheduler: RTL and testbench

//  Sequences BLE TX frames through the input-segmentation/PISO chain. Queues frame

---
 rtl/ble_tx_frame_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_ble_tx_frame_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_tx_frame_scheduler.sv
// BLE TX frame scheduler: queues frame descriptors, arms the segmentation/PISO
// chain one frame at a time, detects frame end and enforces the inter-frame space.
module ble_tx_frame_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_W   = 2,
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [15:0]      desc_header_size,
  input  logic [15:0]      desc_payload_size,
  input  logic [15:0]      ifs_cycles,
  input  logic             stop_req,
  input  logic             seg_enable,
  input  logic             seg_valid_payload,
  output logic             valid_in,
  output logic             enable_chain,
  output logic [15:0]      header_size,
  output logic [15:0]      payload_size,
  output logic             busy,
  output logic             frame_done,
  output logic             err_desc,
  output logic             err_timeout,
  output logic [PTR_W:0]   fifo_level
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE,
    S_IFS
  } state_t;

  state_t state, state_next;

  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [31:0]    mem [DEPTH];
  logic           fifo_full, fifo_empty;
  logic           push, pop, flush;
  logic [31:0]    head;
  logic           head_ok;

  logic           stop_pend;
  logic           seg_en_q;
  logic           payload_seen;
  logic [19:0]    wd_cnt;
  logic [20:0]    wd_inc;
  logic           wd_fire;
  logic [15:0]    ifs_cnt;
  logic           ifs_load;
  state_t         post_ifs;

  // Descriptor FIFO
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign desc_ready = !fifo_full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign push       = desc_valid && desc_ready;
  assign head       = mem[rd_ptr[PTR_W-1:0]];
  assign head_ok    = (head[31:16] != '0) && (head[15:0] != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {desc_header_size, desc_payload_size};
    end
  end

  // A flush also discards a descriptor pushed in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr + (PTR_W+1)'(push);
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Fires on the TIMEOUT-th RUN cycle; counter is zero on the first RUN cycle.
  assign wd_inc  = {1'b0, wd_cnt} + 21'd1;
  assign wd_fire = (wd_inc >= {1'b0, TIMEOUT});

  assign post_ifs = (!fifo_empty && !stop_pend) ? S_LOAD : S_IDLE;
  assign flush    = stop_pend && (state_next == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    valid_in     = 1'b0;
    enable_chain = 1'b0;
    frame_done   = 1'b0;
    err_desc     = 1'b0;
    err_timeout  = 1'b0;
    pop          = 1'b0;
    ifs_load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty && !stop_req && !stop_pend) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        pop = 1'b1;
        if (!head_ok) begin
          err_desc   = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        valid_in   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        enable_chain = 1'b1;
        if (seg_en_q && !seg_enable && (payload_seen || seg_valid_payload)) begin
          state_next = S_DONE;
        end else if (wd_fire) begin
          err_timeout  = 1'b1;
          enable_chain = 1'b0;
          ifs_load     = 1'b1;
          state_next   = (ifs_cycles == '0) ? post_ifs : S_IFS;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        ifs_load   = 1'b1;
        state_next = (ifs_cycles == '0) ? post_ifs : S_IFS;
      end
      S_IFS: begin
        if (ifs_cnt <= 16'd1) begin
          state_next = post_ifs;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      header_size  <= '0;
      payload_size <= '0;
      stop_pend    <= 1'b0;
      seg_en_q     <= 1'b0;
      payload_seen <= 1'b0;
      wd_cnt       <= '0;
      ifs_cnt      <= '0;
    end else begin
      seg_en_q  <= seg_enable;
      stop_pend <= stop_req || (stop_pend && !flush);
      if (pop) begin
        header_size  <= head[31:16];
        payload_size <= head[15:0];
      end
      if (state == S_ARM) begin
        payload_seen <= 1'b0;
        wd_cnt       <= '0;
      end else if (state == S_RUN) begin
        if (seg_valid_payload) begin
          payload_seen <= 1'b1;
        end
        if (wd_cnt != '1) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
      if (ifs_load) begin
        ifs_cnt <= ifs_cycles;
      end else if ((state == S_IFS) && (ifs_cnt != '0)) begin
        ifs_cnt <= ifs_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ble_tx_frame_scheduler.sv
// Directed bench for ble_tx_frame_scheduler: a per-cycle vector table for a
// single frame, then hand-written sequences for queueing, errors, stop and reset.
module tb_ble_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_header_size;
  logic [15:0] desc_payload_size;
  logic [15:0] ifs_cycles;
  logic        stop_req;
  logic        seg_enable;
  logic        seg_valid_payload;
  logic        valid_in;
  logic        enable_chain;
  logic [15:0] header_size;
  logic [15:0] payload_size;
  logic        busy;
  logic        frame_done;
  logic        err_desc;
  logic        err_timeout;
  logic [2:0]  fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  ble_tx_frame_scheduler #(
    .DEPTH  (4),
    .PTR_W  (2),
    .TIMEOUT(20'd64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_header_size (desc_header_size),
    .desc_payload_size(desc_payload_size),
    .ifs_cycles       (ifs_cycles),
    .stop_req         (stop_req),
    .seg_enable       (seg_enable),
    .seg_valid_payload(seg_valid_payload),
    .valid_in         (valid_in),
    .enable_chain     (enable_chain),
    .header_size      (header_size),
    .payload_size     (payload_size),
    .busy             (busy),
    .frame_done       (frame_done),
    .err_desc         (err_desc),
    .err_timeout      (err_timeout),
    .fifo_level       (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [15:0] hdr;
    logic [15:0] pay;
    logic        se;
    logic        svp;
    logic        vin;
    logic        en;
    logic        bsy;
    logic        fd;
    logic        ed;
    logic [2:0]  lvl;
    logic        rdy;
    logic [15:0] ohdr;
    logic [15:0] opay;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic dv, logic [15:0] h, logic [15:0] p, logic se, logic svp,
                              logic vin, logic en, logic bsy, logic fd, logic ed,
                              logic [2:0] lvl, logic [15:0] oh, logic [15:0] op);
    vec_t v;
    v.dv = dv; v.hdr = h; v.pay = p; v.se = se; v.svp = svp;
    v.vin = vin; v.en = en; v.bsy = bsy; v.fd = fd; v.ed = ed;
    v.lvl = lvl; v.rdy = 1'b1; v.ohdr = oh; v.opay = op;
    return v;
  endfunction

  function automatic logic [41:0] outs();
    return {valid_in, enable_chain, busy, frame_done, err_desc, err_timeout,
            fifo_level, desc_ready, header_size, payload_size};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arm(input logic [15:0] eh, input logic [15:0] ep);
    int n = 0;
    while (!valid_in && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("arm_seen", valid_in, 1'b1);
    chk("arm_sizes", {header_size, payload_size}, {eh, ep});
  endtask

  task automatic finish_chain();
    int n = 0;
    cyc(); seg_enable = 1'b1;
    cyc(); seg_valid_payload = 1'b1;
    cyc(); seg_valid_payload = 1'b0;
    cyc(); seg_enable = 1'b0;
    while (!frame_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done", frame_done, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, {busy, fifo_level}, 4'd0);
  endtask

  task automatic no_arm(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_in) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic push1(input logic [15:0] h, input logic [15:0] p);
    cyc(); desc_valid = 1'b1; desc_header_size = h; desc_payload_size = p;
    cyc(); desc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    desc_valid = 1'b0; desc_header_size = '0; desc_payload_size = '0;
    ifs_cycles = 16'd10; stop_req = 1'b0;
    seg_enable = 1'b0; seg_valid_payload = 1'b0;
    #1;
    chk("reset_state", outs(), {5'b0, 1'b0, 3'd0, 1'b1, 32'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single frame (8,24), ifs=10: cycle-by-cycle expectations
    tbl[0] = mk(1, 8, 24, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2] = mk(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 0,  0, 0,  1, 0, 1, 0, 0, 0, 8, 24);
    tbl[4] = mk(0, 0, 0,  1, 0,  0, 1, 1, 0, 0, 0, 8, 24);
    tbl[5] = mk(0, 0, 0,  1, 1,  0, 1, 1, 0, 0, 0, 8, 24);
    tbl[6] = mk(0, 0, 0,  1, 0,  0, 1, 1, 0, 0, 0, 8, 24);
    tbl[7] = mk(0, 0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 8, 24);
    tbl[8] = mk(0, 0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 8, 24);
    for (int i = 9; i < 19; i++) begin
      tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 24);
    end
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 24);

    for (int i = 0; i < 20; i++) begin
      cyc();
      desc_valid = tbl[i].dv; desc_header_size = tbl[i].hdr; desc_payload_size = tbl[i].pay;
      seg_enable = tbl[i].se; seg_valid_payload = tbl[i].svp;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), outs(),
          {tbl[i].vin, tbl[i].en, tbl[i].bsy, tbl[i].fd, tbl[i].ed, 1'b0,
           tbl[i].lvl, tbl[i].rdy, tbl[i].ohdr, tbl[i].opay});
    end
    cyc(); desc_valid = 1'b0; seg_enable = 1'b0; seg_valid_payload = 1'b0;

    // Fill the FIFO while frame A is stalled in RUN
    ifs_cycles = 16'd2;
    push1(16'd10, 16'd5);
    wait_arm(16'd10, 16'd5);
    cyc(); desc_valid = 1'b1; desc_header_size = 16'd11; desc_payload_size = 16'd5;
    cyc(); desc_header_size = 16'd12;
    cyc(); desc_header_size = 16'd13;
    cyc(); desc_header_size = 16'd14;
    cyc(); desc_header_size = 16'd15;
    @(negedge clk);
    chk("fifo_full", {desc_ready, fifo_level}, {1'b0, 3'd4});
    cyc(); desc_valid = 1'b0;
    @(negedge clk);
    chk("fifo_5th_ignored", fifo_level, 3'd4);
    finish_chain();
    for (int k = 11; k <= 14; k++) begin
      wait_arm(16'(k), 16'd5);
      finish_chain();
    end
    wait_idle("queue_drained");
    no_arm("no_fifth_frame", 8);

    // Invalid descriptor dropped at pop, next one runs
    cyc(); desc_valid = 1'b1; desc_header_size = 16'd0; desc_payload_size = 16'd16;
    cyc(); desc_header_size = 16'd8; desc_payload_size = 16'd8;
    cyc(); desc_valid = 1'b0;
    @(negedge clk);
    chk("err_desc_pulse", {err_desc, valid_in}, 2'b10);
    @(negedge clk);
    chk("err_desc_one_cycle", err_desc, 1'b0);
    wait_arm(16'd8, 16'd8);
    finish_chain();
    wait_idle("after_err_desc");

    // stop_req mid-RUN with two descriptors queued
    ifs_cycles = 16'd3;
    push1(16'd20, 16'd4);
    wait_arm(16'd20, 16'd4);
    cyc(); desc_valid = 1'b1; desc_header_size = 16'd21; desc_payload_size = 16'd4;
    cyc(); desc_header_size = 16'd22;
    cyc(); desc_valid = 1'b0; stop_req = 1'b1;
    cyc(); stop_req = 1'b0;
    @(negedge clk);
    chk("stop_no_early_flush", {busy, fifo_level}, {1'b1, 3'd2});
    finish_chain();
    wait_idle("stop_flushed");
    no_arm("stop_no_more_frames", 10);
    push1(16'd5, 16'd5);
    wait_arm(16'd5, 16'd5);
    finish_chain();
    wait_idle("after_stop_resume");

    // Watchdog: chain stalled with seg_enable stuck high
    ifs_cycles = 16'd2;
    push1(16'd7, 16'd7);
    wait_arm(16'd7, 16'd7);
    seg_enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 100);
    chk("timeout_cycle", n, 64);
    chk("timeout_chain_dropped", {err_timeout, enable_chain, frame_done}, 3'b100);
    cyc(); seg_enable = 1'b0;
    wait_idle("after_timeout");

    // Asynchronous reset in the middle of RUN
    push1(16'd9, 16'd9);
    wait_arm(16'd9, 16'd9);
    cyc(); seg_enable = 1'b1; desc_valid = 1'b1; desc_header_size = 16'd3; desc_payload_size = 16'd3;
    cyc(); desc_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_running", {enable_chain, fifo_level}, {1'b1, 3'd1});
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), {5'b0, 1'b0, 3'd0, 1'b1, 32'h0});
    seg_enable = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    no_arm("reset_fifo_lost", 6);
    push1(16'd6, 16'd6);
    wait_arm(16'd6, 16'd6);
    finish_chain();
    wait_idle("after_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
